// File: rtl/vc_output_arbiter.sv
// Two-VC output arbiter: round-robin grants from two input controllers into a
// per-VC buffer on the internal phase, drained downstream on the external phase.
module vc_output_arbiter #(
    parameter int PKT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             polarity,
    input  logic             req_1,
    input  logic             req_2,
    input  logic [PKT_W-1:0] data_1,
    input  logic [PKT_W-1:0] data_2,
    output logic             grant_1,
    output logic             grant_2,
    input  logic             ro,
    output logic             so,
    output logic [PKT_W-1:0] dout
);

    localparam int VC_BIT = PKT_W - 1;
    localparam int HOP_HI = 55;
    localparam int HOP_LO = 48;

    // Pointer encoding: 0 prefers requester 1, 1 prefers requester 2.
    typedef enum logic {
        PREF_REQ1 = 1'b0,
        PREF_REQ2 = 1'b1
    } pref_e;

    logic [1:0]       r_full;
    logic [PKT_W-1:0] r_buf [2];
    pref_e            r_ptr [2];

    logic             w_int_vc;
    logic             w_ext_vc;
    logic             w_elig_1;
    logic             w_elig_2;
    logic             w_grant_1;
    logic             w_grant_2;
    logic             w_grant_any;
    logic             w_drain;
    logic [PKT_W-1:0] w_win_data;
    logic [PKT_W-1:0] w_captured;

    assign w_int_vc = polarity;
    assign w_ext_vc = ~polarity;

    // Eligibility is gated by reset so no grant escapes while the block is held.
    assign w_elig_1 = reset & req_1 & (data_1[VC_BIT] == w_int_vc) & ~r_full[w_int_vc];
    assign w_elig_2 = reset & req_2 & (data_2[VC_BIT] == w_int_vc) & ~r_full[w_int_vc];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        w_grant_1 = 1'b0;
        w_grant_2 = 1'b0;
        if (w_elig_1 && w_elig_2) begin
            if (r_ptr[w_int_vc] == PREF_REQ1) begin
                w_grant_1 = 1'b1;
            end else begin
                w_grant_2 = 1'b1;
            end
        end else begin
            w_grant_1 = w_elig_1;
            w_grant_2 = w_elig_2;
        end
    end

    assign w_grant_any = w_grant_1 | w_grant_2;
    assign w_win_data  = w_grant_2 ? data_2 : data_1;

    always_comb begin
        w_captured                 = w_win_data;
        w_captured[HOP_HI:HOP_LO]  = w_win_data[HOP_HI:HOP_LO] >> 1;
    end

    assign w_drain = r_full[w_ext_vc] & ro;

    assign grant_1 = w_grant_1;
    assign grant_2 = w_grant_2;
    assign so      = r_full[w_ext_vc];
    assign dout    = r_buf[w_ext_vc];

    // Capture and drain always address opposite buffers, so both may fire together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 2'b00;
            // NOTE: the packet buffers are reset too, because dout must read
            // zero during and straight after reset, not stale packet contents.
            for (int v = 0; v < 2; v++) begin
                r_buf[v] <= '0;
                r_ptr[v] <= PREF_REQ1;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block sampling pre-edge values, independent of statement order.
            if (w_grant_any) begin
                r_buf[w_int_vc]  <= w_captured;
                r_full[w_int_vc] <= 1'b1;
                r_ptr[w_int_vc]  <= w_grant_1 ? PREF_REQ2 : PREF_REQ1;
            end
            if (w_drain) begin
                r_full[w_ext_vc] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed, table-driven bench for vc_output_arbiter: one row per clock cycle,
// plus a hand-written sequence for asynchronous reset in the middle of traffic.
module tb_vc_output_arbiter;

    localparam int PKT_W = 64;

    logic             clk;
    logic             reset;
    logic             polarity;
    logic             req_1;
    logic             req_2;
    logic [PKT_W-1:0] data_1;
    logic [PKT_W-1:0] data_2;
    logic             grant_1;
    logic             grant_2;
    logic             ro;
    logic             so;
    logic [PKT_W-1:0] dout;

    int n_pass  = 0;
    int n_total = 0;

    vc_output_arbiter #(.PKT_W(PKT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .req_1    (req_1),
        .req_2    (req_2),
        .data_1   (data_1),
        .data_2   (data_2),
        .grant_1  (grant_1),
        .grant_2  (grant_2),
        .ro       (ro),
        .so       (so),
        .dout     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             pol;
        logic             r1;
        logic             r2;
        logic [PKT_W-1:0] d1;
        logic [PKT_W-1:0] d2;
        logic             ro;
        logic             e_g1;
        logic             e_g2;
        logic             e_so;
        logic [PKT_W-1:0] e_dout;
    } vec_t;

    vec_t vecs[$];

    // Packet builder; reserved bits carry a fixed non-zero pattern so any
    // corruption of them is visible on dout.
    function automatic logic [PKT_W-1:0] mk(input logic vc, input logic dir,
                                            input logic [7:0] hop,
                                            input logic [15:0] src,
                                            input logic [31:0] pay);
        mk = {vc, dir, 6'h15, hop, src, pay};
    endfunction

    task automatic add(input logic rst_n, input logic pol, input logic r1,
                       input logic r2, input logic [PKT_W-1:0] d1,
                       input logic [PKT_W-1:0] d2, input logic ro_i,
                       input logic g1, input logic g2, input logic s,
                       input logic [PKT_W-1:0] dd);
        vec_t v;
        v.rst_n = rst_n; v.pol = pol; v.r1 = r1; v.r2 = r2;
        v.d1 = d1; v.d2 = d2; v.ro = ro_i;
        v.e_g1 = g1; v.e_g2 = g2; v.e_so = s; v.e_dout = dd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [PKT_W-1:0] act,
                         input logic [PKT_W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_outs(input string tag, input logic g1, input logic g2,
                              input logic s, input logic [PKT_W-1:0] dd);
        check({tag, " grant_1"}, {63'b0, grant_1}, {63'b0, g1});
        check({tag, " grant_2"}, {63'b0, grant_2}, {63'b0, g2});
        check({tag, " so"},      {63'b0, so},      {63'b0, s});
        check({tag, " dout"},    dout,             dd);
    endtask

    logic [PKT_W-1:0] pa, pa_q, pb1, pb1_q, pb2, pb2_q;
    logic [PKT_W-1:0] pc1, pc1_q, pc2, pc2_q, pd, pe1, pe1_q, z;

    initial begin
        reset = 1'b0; polarity = 1'b0; req_1 = 1'b0; req_2 = 1'b0;
        data_1 = '0;  data_2 = '0;     ro = 1'b0;

        z     = '0;
        pa    = mk(1'b0, 1'b0, 8'h07, 16'h0001, 32'h0000_0001);
        pa_q  = mk(1'b0, 1'b0, 8'h03, 16'h0001, 32'h0000_0001);
        pb1   = mk(1'b1, 1'b1, 8'h10, 16'h0001, 32'h0000_00B1);
        pb1_q = mk(1'b1, 1'b1, 8'h08, 16'h0001, 32'h0000_00B1);
        pb2   = mk(1'b1, 1'b0, 8'h20, 16'h0002, 32'h0000_00B2);
        pb2_q = mk(1'b1, 1'b0, 8'h10, 16'h0002, 32'h0000_00B2);
        pc1   = mk(1'b0, 1'b1, 8'h02, 16'h0001, 32'h0000_00C1);
        pc1_q = mk(1'b0, 1'b1, 8'h01, 16'h0001, 32'h0000_00C1);
        pc2   = mk(1'b0, 1'b0, 8'h03, 16'h0002, 32'h0000_00C2);
        pc2_q = mk(1'b0, 1'b0, 8'h01, 16'h0002, 32'h0000_00C2);
        pd    = mk(1'b0, 1'b1, 8'h00, 16'h0002, 32'h0000_000D);
        pe1   = mk(1'b1, 1'b0, 8'hFF, 16'h0001, 32'h0000_00E1);
        pe1_q = mk(1'b1, 1'b0, 8'h7F, 16'h0001, 32'h0000_00E1);

        //  rst pol r1 r2 d1   d2   ro  g1 g2 so dout
        // Power-up: reset held two cycles with live requests.
        add(0, 0, 1, 1, pa,  pa,  1,  0, 0, 0, z);
        add(0, 1, 1, 1, pb1, pb2, 1,  0, 0, 0, z);
        // Single request, hop 0x07 -> 0x03, visible on the next odd phase.
        add(1, 0, 1, 0, pa,  z,   0,  1, 0, 0, z);
        add(1, 1, 0, 0, z,   z,   0,  0, 0, 1, pa_q);
        add(1, 1, 0, 0, z,   z,   1,  0, 0, 1, pa_q);
        add(1, 1, 0, 0, z,   z,   0,  0, 0, 0, pa_q);   // drained, contents held
        // VC1 contention with drain in between: 1,2,1,2.
        add(1, 1, 1, 1, pb1, pb2, 1,  1, 0, 0, pa_q);
        add(1, 0, 0, 0, z,   z,   1,  0, 0, 1, pb1_q);
        add(1, 1, 1, 1, pb1, pb2, 1,  0, 1, 0, pa_q);
        add(1, 0, 0, 0, z,   z,   1,  0, 0, 1, pb2_q);
        add(1, 1, 1, 1, pb1, pb2, 1,  1, 0, 0, pa_q);
        add(1, 0, 0, 0, z,   z,   1,  0, 0, 1, pb1_q);
        add(1, 1, 1, 1, pb1, pb2, 1,  0, 1, 0, pa_q);
        // VC0 pointer still reflects the single grant to requester 1 earlier.
        add(1, 0, 1, 1, pc1, pc2, 1,  0, 1, 1, pb2_q);
        // Backpressure on buf0: three odd phases with ro=0, blocked even phases.
        add(1, 1, 0, 0, z,   z,   0,  0, 0, 1, pc2_q);
        add(1, 0, 1, 0, pc1, z,   0,  0, 0, 0, pb2_q);
        add(1, 1, 0, 0, z,   z,   0,  0, 0, 1, pc2_q);
        add(1, 0, 1, 0, pc1, z,   0,  0, 0, 0, pb2_q);
        add(1, 1, 0, 0, z,   z,   0,  0, 0, 1, pc2_q);
        add(1, 1, 0, 0, z,   z,   1,  0, 0, 1, pc2_q);
        add(1, 0, 1, 0, pc1, z,   0,  1, 0, 0, pb2_q);
        // VC mismatch, then the same packet (hop 0x00) granted on its phase.
        add(1, 1, 0, 1, z,   pd,  1,  0, 0, 1, pc1_q);
        add(1, 0, 0, 1, z,   pd,  1,  0, 1, 0, pb2_q);
        add(1, 1, 0, 0, z,   z,   0,  0, 0, 1, pd);
        // Fill buf1 too (hop 0xFF -> 0x7F); both buffers now full.
        add(1, 1, 1, 0, pe1, z,   0,  1, 0, 1, pd);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset    = vecs[i].rst_n;
            polarity = vecs[i].pol;
            req_1    = vecs[i].r1;
            req_2    = vecs[i].r2;
            data_1   = vecs[i].d1;
            data_2   = vecs[i].d2;
            ro       = vecs[i].ro;
            #1;
            check_outs($sformatf("row%0d", i), vecs[i].e_g1, vecs[i].e_g2,
                       vecs[i].e_so, vecs[i].e_dout);
        end

        // Both buffers full: each phase sees its opposite buffer.
        @(negedge clk);
        polarity = 1'b0; req_1 = 1'b0; req_2 = 1'b0; ro = 1'b0;
        #1 check_outs("full_even", 1'b0, 1'b0, 1'b1, pe1_q);
        polarity = 1'b1;
        #1 check_outs("full_odd", 1'b0, 1'b0, 1'b1, pd);

        // Asynchronous reset with no clock edge: outputs drop at once, and
        // grants stay low even though the cleared buffers would admit requests.
        req_1 = 1'b1; req_2 = 1'b1; data_1 = pb1; data_2 = pb2; ro = 1'b1;
        reset = 1'b0;
        #1 check_outs("rst_async_odd", 1'b0, 1'b0, 1'b0, z);
        polarity = 1'b0; data_1 = pc1; data_2 = pc2;
        #1 check_outs("rst_async_even", 1'b0, 1'b0, 1'b0, z);
        @(negedge clk);
        check_outs("rst_held", 1'b0, 1'b0, 1'b0, z);

        // Release: first contention on each VC goes to requester 1.
        reset = 1'b1; polarity = 1'b0;
        #1 check_outs("post_rst_vc0", 1'b1, 1'b0, 1'b0, z);
        @(negedge clk);
        polarity = 1'b1; data_1 = pb1; data_2 = pb2;
        #1 check_outs("post_rst_vc1", 1'b1, 1'b0, 1'b1, pc1_q);
        @(negedge clk);
        req_1 = 1'b0; req_2 = 1'b0; polarity = 1'b0; ro = 1'b0;
        #1 check_outs("post_rst_cap1", 1'b0, 1'b0, 1'b1, pb1_q);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vc_output_arbiter.md
VC_OUTPUT_ARBITER -- requirements
Module: vc_output_arbiter

Interface
REQ-001 Parameter PKT_W, default 64, packet width; field layout: [63] vc, [62] dir, [61:56] reserved, [55:48] hop, [47:32] source, [31:0] payload.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low (asserted at 0).
REQ-004 polarity  input  1  phase: 0 = internal phase on even VC, external phase on odd VC; 1 = the reverse.
REQ-005 req_1, req_2  input  1  request from input controller 1 (CW) and 2 (PE).
REQ-006 data_1, data_2  input  PKT_W  packet offered by each requester; vc taken from bit [63].
REQ-007 grant_1, grant_2  output  1  grant to each requester; combinational, one-hot or zero.
REQ-008 ro  input  1  downstream ready.
REQ-009 so  output  1  downstream send-valid.
REQ-010 dout  output  PKT_W  packet to downstream.

Function
REQ-011 Two internal buffers buf[0] (even) and buf[1] (odd), each PKT_W with a full flag.
REQ-012 Requester i is eligible when: req_i=1, data_i[63]=polarity, and full[polarity]=0.
REQ-013 Only eligible requesters are granted; at most one grant per cycle; no grant when neither is eligible.
REQ-014 Arbitration is round-robin with one pointer per VC (ptr[0], ptr[1]); ptr[v] names the requester preferred on VC v.
REQ-015 Both eligible: grant goes to ptr[polarity].
REQ-016 One eligible: that requester is granted regardless of pointer.
REQ-017 On any grant, ptr[polarity] is set to the non-winning requester at the posedge; ptr[~polarity] is unchanged.
REQ-018 On grant, at posedge: buf[polarity] captures the winner's data; hop field [55:48] is logically shifted right 1 bit (e.g. 0000_0111 -> 0000_0011); all other fields are unchanged; full[polarity] is set.
REQ-019 Capture latency is 1 cycle; a granted packet is visible on dout no earlier than the next cycle whose polarity is opposite.
REQ-020 External side: so = full[~polarity]; dout = buf[~polarity] (combinational).
REQ-021 At posedge with so=1 and ro=1, full[~polarity] clears; buffer contents are held (not zeroed).
REQ-022 so=1 with ro=0: full flag and dout are held; the packet is not dropped.
REQ-023 Internal write and external drain always target different buffers; both in the same cycle are legal and independent.
REQ-024 A full buffer blocks grants on its VC until drained; requesters hold req and data until granted.
REQ-025 Hop field 0000_0000 is captured unchanged (shift of zero); no error is flagged.

Reset
REQ-026 reset=0 asynchronously clears full[0], full[1], both buffers to 0, and sets ptr[0]=ptr[1]=requester 1.
REQ-027 While reset=0: grant_1=grant_2=0, so=0, dout=0, regardless of other inputs.
REQ-028 Reset asserted mid-operation discards buffered packets; after release, the first cycle behaves as after power-up.

Verification
REQ-029 Power-up: reset=0 for 2 cycles, random req/data -> grants 0, so 0, dout 0 throughout.
REQ-030 Single request: polarity=0, req_1=1, data_1 vc=0 hop=0x07 payload=0x1 -> grant_1=1 that cycle; next cycle polarity=1: so=1, dout hop=0x03, payload=0x1.
REQ-031 Contention: both requesters on VC 1 for 4 odd-phase cycles, draining each time with ro=1 -> grants alternate 1,2,1,2; ptr[0] is unaffected (next even contention grants requester 1).
REQ-032 Backpressure: buf[0] full, ro=0 for 3 cycles -> so held 1, dout stable; vc=0 requests at polarity=0 get no grant; ro=1 -> full clears, next even phase grants.
REQ-033 VC mismatch: polarity=1, req_2=1 with vc=0 -> grant_2=0; at polarity=0 the same packet is granted.
REQ-034 Reset mid-operation: both buffers full, reset=0 for 1 cycle -> so=0 immediately; after release the first contention on each VC grants requester 1.
